// File: rtl/seq_datapath.sv
// seq_datapath: bus datapath with an internal T-state sequencer.
// One register-register operation per accepted start: ALU ops, LDI, MFHI,
// MFLO and, when SEQ_DATAPATH_MUL_EN is defined, an iterative unsigned MUL.
// All register traffic goes over a single internal bus.
//
// Ports:
//   clock          rising-edge clock
//   clear          synchronous active-high reset
//   start          operation request, sampled only in IDLE
//   op             opcode (0 ADD,1 SUB,2 AND,3 OR,4 SHL,5 SHR,6 MUL,7 LDI,8 MFHI,9 MFLO)
//   ra, rb, rc     destination, source 1, source 2 register selects
//   imm            immediate for LDI
//   busy           high in every state except IDLE
//   done           one-cycle completion pulse
//   err            valid with done; illegal op, nothing written
//   rd_sel/rd_data combinational debug read port (R0 reads 0)
//   hi_out/lo_out  HI and LO register contents
//   bus_out        internal bus value (0 when undriven)
//
// Build option: SEQ_DATAPATH_MUL_EN compiles in the shift-add multiplier;
// without it MUL is reported as an illegal op.
module seq_datapath #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  localparam int RSEL_W = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [RSEL_W-1:0] ra,
  input  logic [RSEL_W-1:0] rb,
  input  logic [RSEL_W-1:0] rc,
  input  logic [DATA_W-1:0] imm,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic [RSEL_W-1:0] rd_sel,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic [DATA_W-1:0] bus_out
);

  localparam int RSEL_SH = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, T1, T2, T3, MULT, DONE} stateT;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SHL  = 4'd4,
    OP_SHR  = 4'd5,
    OP_MUL  = 4'd6,
    OP_LDI  = 4'd7,
    OP_MFHI = 4'd8,
    OP_MFLO = 4'd9
  } opT;

  stateT state, nextState;

  // Operand fields captured on the accepting edge.
  logic [3:0]        opQ;
  logic [RSEL_W-1:0] raQ, rbQ, rcQ;
  logic [DATA_W-1:0] immQ;
  logic              errQ;

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] y, z, hi, lo;
  logic [DATA_W-1:0] bus, aluOut;
  logic [DATA_W-1:0] rbVal, rcVal;

  logic loadY, loadZ, loadRa;
  logic accept, opLegal;

  assign rbVal   = (rbQ == '0) ? '0 : regs[rbQ];
  assign rcVal   = (rcQ == '0) ? '0 : regs[rcQ];
  assign rd_data = (rd_sel == '0) ? '0 : regs[rd_sel];

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign err     = (state == DONE) && errQ;
  assign hi_out  = hi;
  assign lo_out  = lo;
  assign bus_out = bus;

  assign accept = (state == IDLE) && start;

`ifdef SEQ_DATAPATH_MUL_EN
  assign opLegal = (op <= OP_MFLO);
`else
  assign opLegal = (op <= OP_MFLO) && (op != OP_MUL);
`endif

`ifdef SEQ_DATAPATH_MUL_EN
  localparam int CNT_W = (RSEL_SH < 1) ? 1 : RSEL_SH;

  logic [DATA_W-1:0] accHi, mplr;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W:0]   mulSum;
  logic [DATA_W-1:0] mulHiNext, mulLoNext;
  logic              mulInit, mulStep, mulLast;

  // Right-shifting shift-add: {accHi, mplr} holds the partial product with
  // the unconsumed multiplier bits in the low half.
  always_comb begin
    mulSum    = {1'b0, accHi} + {1'b0, (mplr[0] ? y : '0)};
    mulHiNext = mulSum[DATA_W:1];
    mulLoNext = {mulSum[0], mplr[DATA_W-1:1]};
    mulLast   = (cnt == CNT_W'(DATA_W - 1));
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      accHi <= '0;
      mplr  <= '0;
      cnt   <= '0;
    end else if (mulInit) begin
      accHi <= '0;
      mplr  <= bus;
      cnt   <= '0;
    end else if (mulStep) begin
      accHi <= mulHiNext;
      mplr  <= mulLoNext;
      cnt   <= cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    aluOut = '0;
    case (opQ)
      OP_ADD:  aluOut = y + bus;
      OP_SUB:  aluOut = y - bus;
      OP_AND:  aluOut = y & bus;
      OP_OR:   aluOut = y | bus;
      OP_SHL:  aluOut = y << bus[RSEL_SH-1:0];
      OP_SHR:  aluOut = y >> bus[RSEL_SH-1:0];
      default: aluOut = '0;
    endcase
  end

  always_comb begin
    nextState = state;
    bus       = '0;
    loadY     = 1'b0;
    loadZ     = 1'b0;
    loadRa    = 1'b0;
`ifdef SEQ_DATAPATH_MUL_EN
    mulInit   = 1'b0;
    mulStep   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) nextState = opLegal ? T1 : DONE;
      end
      T1: begin
        case (opQ)
          OP_LDI: begin
            bus       = immQ;
            loadRa    = 1'b1;
            nextState = DONE;
          end
          OP_MFHI: begin
            bus       = hi;
            loadRa    = 1'b1;
            nextState = DONE;
          end
          OP_MFLO: begin
            bus       = lo;
            loadRa    = 1'b1;
            nextState = DONE;
          end
          default: begin
            bus       = rbVal;
            loadY     = 1'b1;
            nextState = T2;
          end
        endcase
      end
      T2: begin
        bus = rcVal;
`ifdef SEQ_DATAPATH_MUL_EN
        if (opQ == OP_MUL) begin
          mulInit   = 1'b1;
          nextState = MULT;
        end else begin
          loadZ     = 1'b1;
          nextState = T3;
        end
`else
        loadZ     = 1'b1;
        nextState = T3;
`endif
      end
      T3: begin
        bus       = z;
        loadRa    = 1'b1;
        nextState = DONE;
      end
      MULT: begin
`ifdef SEQ_DATAPATH_MUL_EN
        mulStep = 1'b1;
        if (mulLast) nextState = DONE;
`else
        nextState = IDLE;
`endif
      end
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= nextState;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      opQ  <= '0;
      raQ  <= '0;
      rbQ  <= '0;
      rcQ  <= '0;
      immQ <= '0;
      errQ <= 1'b0;
    end else if (accept) begin
      opQ  <= op;
      raQ  <= ra;
      rbQ  <= rb;
      rcQ  <= rc;
      immQ <= imm;
      errQ <= ~opLegal;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      y <= '0;
      z <= '0;
    end else begin
      if (loadY) y <= bus;
      if (loadZ) z <= aluOut;
    end
  end

  // R0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (loadRa && (raQ != '0)) begin
      regs[raQ] <= bus;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      hi <= '0;
      lo <= '0;
`ifdef SEQ_DATAPATH_MUL_EN
    end else if (mulStep && mulLast) begin
      hi <= mulHiNext;
      lo <= mulLoNext;
`endif
    end
  end

endmodule

// File: doc/seq_datapath.md
# seq_datapath

Parametrised bus datapath with a built-in T-state sequencer. It executes one register-register operation per `start` request over a single shared internal bus: ALU ops, load-immediate, HI/LO moves, and, optionally, an iterative unsigned multiply. It succeeds the hand-strobed datapath by generating the bus-out, register-in, Y, Z, HI and LO enables internally. It sits between the future control unit and memory, and is exposed to the bench through a read port and a bus monitor.

## Interface
Parameters:
- DATA_W, 32, register and bus width (≥8).
- NREGS, 16, general-purpose register count (power of two, ≥2); RSEL_W = $clog2(NREGS) is derived, not overridable.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- clear  in  1  reset, synchronous and active-high.
- start  in  1  operation request; sampled only in IDLE.
- op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHL, 5 SHR, 6 MUL, 7 LDI, 8 MFHI, 9 MFLO; 10–15 illegal.
- ra, rb, rc  in  RSEL_W each  destination, source 1 and source 2 register selects.
- imm  in  DATA_W  immediate for LDI.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = illegal op, nothing written.
- rd_sel  in  RSEL_W  debug read select.
- rd_data  out  DATA_W  combinational read of register rd_sel; R0 reads 0.
- hi_out, lo_out  out  DATA_W  HI and LO register contents.
- bus_out  out  DATA_W  current internal bus value; 0 when no source drives it.

## Operation
- R0 is hardwired to zero. Writes to it are discarded and reads return 0.
- The operand fields (op, ra, rb, rc, imm) are latched on the accepting edge. Later input changes have no effect on the running operation.
- States: IDLE, T1, T2, T3, MULT, DONE.
- Transitions out of IDLE, when start is asserted:
  - ALU op → T1.
  - LDI, MFHI, MFLO → T1.
  - MUL → T1.
  - Illegal op → DONE with err=1.
- ALU ops (0–5):
  - T1: Rb drives the bus; Y loads.
  - T2: Rc drives the bus; Z loads ALU(Y, bus).
  - T3: Z drives the bus; Ra loads.
  - → DONE.
- ALU arithmetic:
  - ADD and SUB wrap modulo 2^DATA_W.
  - SHL and SHR are logical shifts of Y by bus[RSEL_SH-1:0], where RSEL_SH = $clog2(DATA_W); upper bits of the shift amount are ignored.
- LDI, MFHI, MFLO: in T1, imm, HI or LO respectively drives the bus and Ra loads → DONE.
- MUL:
  - T1: Y ← Rb.
  - T2: multiplier ← Rc; the accumulator clears.
  - MULT: DATA_W shift-add iterations, one bit per cycle, unsigned.
  - On the edge that ends the last MULT cycle, HI ← product[2·DATA_W-1:DATA_W] and LO ← product[DATA_W-1:0].
  - No GPR is written.
- DONE: done=1 and busy=1 for exactly one cycle → IDLE.
- start is ignored whenever the state is not IDLE. The earliest next acceptance is the first cycle after DONE.

## Timing
- Reset values: every GPR, Y, Z, HI, LO and the multiplier state are 0. State = IDLE; busy=0, done=0, err=0, bus_out=0.
- Latency from the accepting edge to the done cycle:
  - ALU ops: 4 cycles.
  - LDI, MFHI, MFLO: 2 cycles.
  - Illegal op: 1 cycle.
  - MUL: DATA_W+3 cycles (35 at the default).
- The destination value is visible on rd_data from the done cycle onward.
- clear mid-operation: the operation aborts on that edge and the state goes to IDLE. No partial GPR, HI or LO write occurs, and done is not asserted.
- clear and start in the same cycle: clear wins and the request is dropped.
- Same register as source and destination (e.g., ra=rb): sources are read in T1/T2 before the Ra write in T3, so the old value is used.

## Configuration
- SEQ_DATAPATH_MUL_EN defined: the MULT state, shift-add multiplier and accumulator are compiled in; MUL behaves as above.
- SEQ_DATAPATH_MUL_EN undefined: the multiplier logic is absent. MUL is treated as illegal: DONE after 1 cycle with err=1, and HI/LO are unchanged.

## Test plan
- Reset, then LDI R3 imm=0x0000_0005 → done after 2 cycles; rd_data(R3)=5. Then LDI R0 imm=0xFFFF_FFFF → rd_data(R0)=0.
- R1=0xFFFF_FFFF, R2=1, ADD R4,R1,R2 → done after 4 cycles; R4=0 (wrap). SUB R5,R2,R1 → R5=2.
- R1=0x8000_0001, R2=33, SHR R6,R1,R2 → R6=0x4000_0000 (shift amount 1). SHL R7,R1,R2 → R7=0x0000_0002.
- With MUL_EN: R1=0xFFFF_FFFF, R2=0xFFFF_FFFF, MUL → done 35 cycles after start; HI=0xFFFF_FFFE, LO=0x0000_0001. MFHI R8 → R8=0xFFFF_FFFE. Without MUL_EN: done after 1 cycle with err=1; HI/LO remain 0.
- Start ADD R4,R1,R2 and pulse clear in T2 → no done pulse; all registers 0; busy=0 the next cycle. A start asserted during busy is ignored, and no second done pulse appears.
- op=12 → done and err in 1 cycle; no register changes.
